// File: rtl/text_frame_renderer_if.sv
// text_frame_renderer_if: text/font fetch, SRAM write and display-swap signals of the frame renderer.
interface text_frame_renderer_if;
    logic        paint_done;
    logic [11:0] char_addr;
    logic [25:0] char_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_done;
    logic [19:0] display_base;
    logic        frame_swapped;
    modport master (
        input  paint_done, char_data, font_data, sram_done,
        output char_addr, font_addr, sram_addr, sram_wdata, sram_we_n, sram_oe_n, display_base, frame_swapped
    );
    modport slave (
        output paint_done, char_data, font_data, sram_done,
        input  char_addr, font_addr, sram_addr, sram_wdata, sram_we_n, sram_oe_n, display_base, frame_swapped
    );
endinterface

// File: rtl/text_frame_renderer.sv
// text_frame_renderer: renders a character buffer through an 8x16 font into a double-buffered
// RGB333 SRAM framebuffer, swapping buffers on the rising edge of paint_done once a frame is complete.
module text_frame_renderer #(
    parameter logic [19:0] BUF0_BASE = 20'd0,
    parameter logic [19:0] BUF1_BASE = 20'd307200,
    parameter int          COLS      = 80,
    parameter int          ROWS      = 30
) (
    input logic                   clk,
    input logic                   rst,
    text_frame_renderer_if.master bus
);
    localparam int H_ACTIVE = COLS * 8;
    localparam int V_ACTIVE = ROWS * 16;
    typedef enum logic [2:0] {FETCH_CHAR, FETCH_FONT, LOAD, WRITE, WAIT_SWAP} state_t;
    state_t      r_state, w_next;
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic [8:0]  r_fg, r_bg;
    logic [7:0]  r_shift;
    logic [11:0] r_font_addr, w_font_addr;
    logic [19:0] r_back_base, r_display_base;
    logic        r_pd_q, r_swapped;
    logic        w_ack, w_cell_end, w_line_end, w_frame_end, w_swap;
    assign w_ack       = r_state == WRITE && bus.sram_done;
    assign w_cell_end  = w_ack && r_x[2:0] == 3'd7;
    assign w_line_end  = w_cell_end && r_x == 10'(H_ACTIVE - 1);
    assign w_frame_end = w_line_end && r_y == 9'(V_ACTIVE - 1);
    assign w_swap      = r_state == WAIT_SWAP && bus.paint_done && !r_pd_q;
    assign w_font_addr = {bus.char_data[7:0], r_y[3:0]};
    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= FETCH_CHAR;
        else r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH_CHAR: w_next = FETCH_FONT;
            FETCH_FONT: w_next = LOAD;
            LOAD:       w_next = WRITE;
            WRITE:      w_next = w_frame_end ? WAIT_SWAP : w_cell_end ? FETCH_CHAR : WRITE;
            WAIT_SWAP:  w_next = w_swap ? FETCH_CHAR : WAIT_SWAP;
            default:    w_next = FETCH_CHAR;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x            <= '0;
            r_y            <= '0;
            r_fg           <= '0;
            r_bg           <= '0;
            r_shift        <= '0;
            r_font_addr    <= '0;
            r_back_base    <= BUF1_BASE;
            r_display_base <= BUF0_BASE;
            r_pd_q         <= 1'b0;
            r_swapped      <= 1'b0;
        end else begin
            r_pd_q    <= bus.paint_done;
            r_swapped <= w_swap;
            if (r_state == FETCH_FONT) begin
                r_bg        <= bus.char_data[25:17];
                r_fg        <= bus.char_data[16:8];
                r_font_addr <= w_font_addr;
            end
            if (r_state == LOAD) r_shift <= bus.font_data;
            if (w_ack) begin
                r_shift <= {r_shift[6:0], 1'b0};
                r_x     <= w_line_end ? '0 : r_x + 10'd1;
            end
            if (w_line_end) r_y <= w_frame_end ? '0 : r_y + 9'd1;
            if (w_swap) begin
                r_display_base <= r_back_base;
                r_back_base    <= r_display_base;
            end
        end
    end
    // font address is live from char_data while it is being fetched, then held
    assign bus.char_addr     = 12'(r_y[8:4]) * 12'(COLS) + 12'(r_x[9:3]);
    assign bus.font_addr     = r_state == FETCH_FONT ? w_font_addr : r_font_addr;
    assign bus.sram_addr     = r_state == WRITE ? r_back_base + 20'(r_y) * 20'(H_ACTIVE) + 20'(r_x) : '0;
    assign bus.sram_wdata    = r_state == WRITE ? {r_shift[7] ? r_fg : r_bg, 23'd0} : '0;
    assign bus.sram_we_n     = r_state != WRITE;
    assign bus.sram_oe_n     = 1'b1;
    assign bus.display_base  = r_display_base;
    assign bus.frame_swapped = r_swapped;
endmodule
